// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: settles DWELL cycles per channel, samples y, publishes a 4-bit snapshot.
// Define MUX_SCAN_CONT_EN for free-running continuous scanning; otherwise each start gives one scan.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic [1:0] select,
   output logic [3:0] data_out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg;
   logic [1:0] select_reg;
   logic [3:0] shadow_reg;
   logic [3:0] data_reg;

   // State register plus datapath registers that advance with the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         select_reg <= 2'd0;
         shadow_reg <= 4'd0;
         data_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  select_reg <= 2'd0;
                  cnt_reg    <= 4'd0;
               end
            end
            SETTLE: begin
               if (cnt_reg != CNT_LAST)
                  cnt_reg <= cnt_reg + 4'd1;
            end
            CAPTURE: begin
               shadow_reg[select_reg] <= y;
               if (select_reg != 2'd3) begin
                  select_reg <= select_reg + 2'd1;
                  cnt_reg    <= 4'd0;
               end else begin
                  // The shadow register has not absorbed bit 3 yet, so splice y in here
                  data_reg <= {y, shadow_reg[2:0]};
               end
            end
            DONE: begin
`ifdef MUX_SCAN_CONT_EN
               select_reg <= 2'd0;
               cnt_reg    <= 4'd0;
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SETTLE;
         SETTLE:  if (cnt_reg == CNT_LAST) state_next = CAPTURE;
         CAPTURE: state_next = (select_reg == 2'd3) ? DONE : SETTLE;
`ifdef MUX_SCAN_CONT_EN
         DONE:    state_next = SETTLE;
`else
         DONE:    state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         SETTLE, CAPTURE: busy = 1'b1;
         DONE:            done = 1'b1;
         default: ;
      endcase
   end

   assign select   = select_reg;
   assign data_out = data_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (DWELL=2); models the 4:1 mux and checks select stepping, done timing and data_out.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       y;
   logic [1:0] select;
   logic [3:0] data_out;
   logic       busy;
   logic       done;

   logic [3:0] mux_in = 4'd0;
   logic       noise = 1'b0;
   logic [3:0] exp_data = 4'd0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   assign y = mux_in[select] ^ noise;

   mux_scan_ctrl #(.DWELL(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .y(y),
      .select(select), .data_out(data_out), .busy(busy), .done(done)
   );

   typedef struct {
      logic [3:0] inputs;
      logic [3:0] expected;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, expv);
      end
   endtask

   // One scan from a start pulse; optional noise during SETTLE and a stray start pulse mid-scan
   task automatic run_scan(input logic [3:0] inp, input logic [3:0] expv,
                           input bit use_noise, input bit stray_start);
      mux_in = inp;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      noise = use_noise;
      check("start_busy", busy, 1);
      check("start_sel", select, 0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         noise = use_noise && (k % 3 != 2);
         if (stray_start) start = (k == 4);
         if (k < 12) begin
            check("scan_sel", select, k / 3);
            check("scan_busy", busy, 1);
            check("scan_done", done, 0);
            if (k == 6) check("data_hold", data_out, exp_data);
         end else begin
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_data", data_out, expv);
            $display("scan inputs=%b data_out=%b", inp, data_out);
         end
      end
      noise = 1'b0;
      start = 1'b0;
      exp_data = expv;
      @(posedge clk); #1;
      check("after_done", done, 0);
`ifdef MUX_SCAN_CONT_EN
      check("cont_restart_sel", select, 0);
      check("cont_restart_busy", busy, 1);
`else
      check("idle_sel", select, 3);
      check("idle_busy", busy, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_no_done", done, 0);
      end
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_sel", select, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      exp_data = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{4'b0101, 4'b0101};
      vecs[1] = '{4'b1000, 4'b1000};
      vecs[2] = '{4'b1111, 4'b1111};
      vecs[3] = '{4'b0000, 4'b0000};
      vecs[4] = '{4'b0110, 4'b0110};

      #2;
      check("por_sel", select, 0);
      check("por_data", data_out, 0);
      check("por_busy", busy, 0);
      check("por_done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

`ifdef MUX_SCAN_CONT_EN
      // Single start, then scanning continues with start low: done every 13 cycles
      mux_in = 4'b1001;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k < 12) check("cont_no_done", done, 0);
         end
         check("cont_done", done, 1);
         check("cont_data", data_out, 4'b1001);
         $display("cont period=%0d data_out=%b", p, data_out);
         mux_in = 4'b0011;
         @(posedge clk); #1;
         check("cont_sel0", select, 0);
         check("cont_busy", busy, 1);
         mux_in = 4'b1001;
      end
      do_reset();
      repeat (15) begin
         @(posedge clk); #1;
         check("cont_rst_idle", done, 0);
      end
`else
      for (int i = 0; i < 5; i++)
         run_scan(vecs[i].inputs, vecs[i].expected, 1'b0, 1'b0);

      // Second scan updates data_out only at its own done
      run_scan(4'b0011, 4'b0011, 1'b0, 1'b0);

      // Stray start while busy: single done, unchanged latency
      run_scan(4'b1010, 4'b1010, 1'b0, 1'b1);

      // y garbage during SETTLE, correct during CAPTURE
      run_scan(4'b1100, 4'b1100, 1'b1, 1'b0);

      // Reset during channel 2 SETTLE
      mux_in = 4'b1111;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("mid_sel2", select, 2);
      do_reset();
      repeat (14) begin
         @(posedge clk); #1;
         check("abort_no_done", done, 0);
      end
      run_scan(4'b0101, 4'b0101, 1'b0, 1'b0);

      // Start held high: rescans on first IDLE cycle after DONE
      mux_in = 4'b0001;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      repeat (12) @(posedge clk);
      #1;
      check("held_done", done, 1);
      check("held_data", data_out, 4'b0001);
      mux_in = 4'b1110;
      @(posedge clk); #1;
      check("held_idle_busy", busy, 0);
      check("held_idle_sel", select, 3);
      @(posedge clk); #1;
      check("held_restart_busy", busy, 1);
      check("held_restart_sel", select, 0);
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("held_done2", done, 1);
      check("held_data2", data_out, 4'b1110);
      $display("held-start rescan data_out=%b", data_out);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
